// File: rtl/regfile_sb.sv
// Multi-read-port register file with per-register busy scoreboard and a sequenced clear sweep.
// Optional same-cycle write forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_sb #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned NREGS = 32,
   parameter int unsigned NREAD = 2,
   localparam int unsigned AW   = $clog2(NREGS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREAD*AW-1:0]   readAddr,
   output logic [NREAD*XLEN-1:0] readData,
   output logic [NREAD-1:0]      readBusy,
   input  logic                  writeEnable,
   input  logic [AW-1:0]         writeAddr,
   input  logic [XLEN-1:0]       writeData,
   input  logic                  issueEnable,
   input  logic [AW-1:0]         issueAddr,
   input  logic                  clearReq,
   output logic                  clearBusy
);

   typedef enum logic {StIdle, StSweep} state_e;

   state_e            state_q, state_d;
   logic [AW-1:0]     index_q, index_d;
   logic [XLEN-1:0]   regs_q [NREGS];
   logic [XLEN-1:0]   regs_d [NREGS];
   logic [NREGS-1:0]  busy_q, busy_d;

   logic              idle;
   logic              wr_ok;
   logic              iss_ok;
   logic [AW-1:0]     rd_addr;

   assign idle      = (state_q == StIdle);
   assign wr_ok     = writeEnable && (writeAddr != '0) && idle;
   assign iss_ok    = issueEnable && (issueAddr != '0) && idle;
   assign clearBusy = (state_q == StSweep);

   always_comb begin
      state_d = state_q;
      index_d = index_q;
      regs_d  = regs_q;
      busy_d  = busy_q;
      unique case (state_q)
         StIdle: begin
            if (wr_ok) begin
               regs_d[writeAddr] = writeData;
               busy_d[writeAddr] = 1'b0;
            end
            // Issue after write so a same-cycle new producer leaves the register busy.
            if (iss_ok) begin
               busy_d[issueAddr] = 1'b1;
            end
            if (clearReq) begin
               index_d = AW'(1);
               state_d = StSweep;
            end
         end
         StSweep: begin
            regs_d[index_q] = '0;
            busy_d[index_q] = 1'b0;
            index_d         = index_q + AW'(1);
            if (index_q == AW'(NREGS - 1)) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         index_q <= '0;
         busy_q  <= '0;
         for (int i = 0; i < int'(NREGS); i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         index_q <= index_d;
         busy_q  <= busy_d;
         regs_q  <= regs_d;
      end
   end

   // Entry 0 is never written, so it reads as zero and never busy without a special case.
   always_comb begin
      readData = '0;
      readBusy = '0;
      rd_addr  = '0;
      for (int i = 0; i < int'(NREAD); i++) begin
         rd_addr                  = readAddr[i*AW +: AW];
         readData[i*XLEN +: XLEN] = regs_q[rd_addr];
         readBusy[i]              = busy_q[rd_addr];
`ifdef REGFILE_BYPASS_EN
         if (wr_ok && (rd_addr == writeAddr)) begin
            readData[i*XLEN +: XLEN] = writeData;
            readBusy[i]              = iss_ok && (issueAddr == rd_addr);
         end
`else
`endif
      end
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: stimulus queues expected values, a negedge monitor checks them.
module tb_regfile_sb;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int NREAD = 4;
   localparam int AW    = 5;
`ifdef REGFILE_BYPASS_EN
   localparam bit Bypass = 1'b1;
`else
   localparam bit Bypass = 1'b0;
`endif

   logic                  clk;
   logic                  rst;
   logic [NREAD*AW-1:0]   readAddr;
   logic [NREAD*XLEN-1:0] readData;
   logic [NREAD-1:0]      readBusy;
   logic                  writeEnable;
   logic [AW-1:0]         writeAddr;
   logic [XLEN-1:0]       writeData;
   logic                  issueEnable;
   logic [AW-1:0]         issueAddr;
   logic                  clearReq;
   logic                  clearBusy;

   regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) dut (
      .clk         (clk),
      .rst         (rst),
      .readAddr    (readAddr),
      .readData    (readData),
      .readBusy    (readBusy),
      .writeEnable (writeEnable),
      .writeAddr   (writeAddr),
      .writeData   (writeData),
      .issueEnable (issueEnable),
      .issueAddr   (issueAddr),
      .clearReq    (clearReq),
      .clearBusy   (clearBusy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tick = 0;
   always @(posedge clk) tick <= tick + 1;

   // kind: 0 = readData[port], 1 = readBusy[port], 2 = clearBusy
   typedef struct {
      int          tick;
      int          kind;
      int          port;
      logic [31:0] exp;
      string       name;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   logic [31:0] act;
   int          checks = 0;
   int          errors = 0;

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].tick <= tick) begin
         mon_e = sb.pop_front();
         case (mon_e.kind)
            0:       act = readData[mon_e.port*XLEN +: XLEN];
            1:       act = {31'b0, readBusy[mon_e.port]};
            default: act = {31'b0, clearBusy};
         endcase
         checks++;
         if (act !== mon_e.exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", mon_e.name, act, mon_e.exp, $time);
         end
      end
   end

   task automatic push(input int kind, input int port, input logic [31:0] v, input string name);
      exp_t e;
      e.tick = tick;
      e.kind = kind;
      e.port = port;
      e.exp  = v;
      e.name = name;
      sb.push_back(e);
   endtask

   task automatic exp_d(input int p, input logic [31:0] v, input string name);
      push(0, p, v, name);
   endtask

   task automatic exp_b(input int p, input logic b, input string name);
      push(1, p, {31'b0, b}, name);
   endtask

   task automatic exp_c(input logic b, input string name);
      push(2, 0, {31'b0, b}, name);
   endtask

   task automatic set_ra(input int a0, input int a1, input int a2, input int a3);
      readAddr = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      writeEnable = 1'b0;
      issueEnable = 1'b0;
      clearReq    = 1'b0;
   endtask

   initial begin
      rst         = 1'b0;
      quiet();
      writeAddr   = '0;
      writeData   = '0;
      issueAddr   = '0;
      set_ra(1, 2, 3, 4);
      for (int p = 0; p < NREAD; p++) begin
         exp_d(p, 32'h0, "reset_data");
         exp_b(p, 1'b0, "reset_busy");
      end
      exp_c(1'b0, "reset_clearbusy");
      #20;
      rst = 1'b1;

      // Write x1, check bypass/registered visibility.
      cyc();
      writeEnable = 1'b1; writeAddr = 5'd1; writeData = 32'h02312313;
      set_ra(1, 0, 0, 0);
      exp_d(0, Bypass ? 32'h02312313 : 32'h0, "wr_x1_same_cycle");
      exp_b(0, 1'b0, "wr_x1_busy");
      cyc();
      quiet();
      exp_d(0, 32'h02312313, "wr_x1_next_cycle");

      // x0 protection.
      cyc();
      writeEnable = 1'b1; writeAddr = 5'd0; writeData = 32'hFFFFFFFF;
      issueEnable = 1'b1; issueAddr = 5'd0;
      set_ra(0, 0, 0, 1);
      for (int p = 0; p < 3; p++) begin
         exp_d(p, 32'h0, "x0_data_same");
         exp_b(p, 1'b0, "x0_busy_same");
      end
      exp_d(3, 32'h02312313, "x1_kept");
      cyc();
      quiet();
      for (int p = 0; p < 3; p++) begin
         exp_d(p, 32'h0, "x0_data_after");
         exp_b(p, 1'b0, "x0_busy_after");
      end

      // Scoreboard: issue x5, write it two cycles later.
      cyc();
      issueEnable = 1'b1; issueAddr = 5'd5;
      set_ra(5, 7, 0, 0);
      exp_b(0, 1'b0, "x5_busy_s0");
      cyc();
      quiet();
      exp_b(0, 1'b1, "x5_busy_s1");
      cyc();
      writeEnable = 1'b1; writeAddr = 5'd5; writeData = 32'hA5A5A5A5;
      exp_b(0, Bypass ? 1'b0 : 1'b1, "x5_busy_s2");
      exp_d(0, Bypass ? 32'hA5A5A5A5 : 32'h0, "x5_data_s2");
      cyc();
      quiet();
      exp_b(0, 1'b0, "x5_busy_s3");
      exp_d(0, 32'hA5A5A5A5, "x5_data_s3");

      // Issue and write to x7 together: new producer keeps it busy.
      cyc();
      writeEnable = 1'b1; writeAddr = 5'd7; writeData = 32'h00000077;
      issueEnable = 1'b1; issueAddr = 5'd7;
      exp_d(1, Bypass ? 32'h00000077 : 32'h0, "x7_data_same");
      exp_b(1, Bypass ? 1'b1 : 1'b0, "x7_busy_same");
      cyc();
      quiet();
      exp_d(1, 32'h00000077, "x7_data_after");
      exp_b(1, 1'b1, "x7_busy_after");

      // Multi-port reads.
      for (int i = 1; i <= 4; i++) begin
         cyc();
         writeEnable = 1'b1; writeAddr = AW'(i); writeData = 32'h11111111 * i;
         set_ra(0, 0, 0, 0);
      end
      cyc();
      quiet();
      set_ra(1, 2, 3, 4);
      exp_d(0, 32'h11111111, "mp_x1");
      exp_d(1, 32'h22222222, "mp_x2");
      exp_d(2, 32'h33333333, "mp_x3");
      exp_d(3, 32'h44444444, "mp_x4");
      cyc();
      set_ra(3, 3, 3, 3);
      for (int p = 0; p < NREAD; p++) begin
         exp_d(p, 32'h33333333, "mp_all_x3");
         exp_b(p, 1'b0, "mp_all_x3_busy");
      end

      // Clear sweep.
      for (int i = 1; i < NREGS; i++) begin
         cyc();
         writeEnable = 1'b1; writeAddr = AW'(i); writeData = 32'h10000000 + i;
      end
      cyc();
      quiet();
      issueEnable = 1'b1; issueAddr = 5'd9;
      cyc();
      quiet();
      clearReq = 1'b1;
      set_ra(31, 2, 9, 3);
      exp_c(1'b0, "sweep_pulse_cb");
      for (int k = 1; k < NREGS; k++) begin
         cyc();
         clearReq    = (k == 5);
         writeEnable = 1'b1; writeAddr = 5'd2; writeData = 32'hDEADBEEF;
         issueEnable = 1'b1; issueAddr = 5'd3;
         exp_c(1'b1, "sweep_cb");
         exp_d(0, 32'h1000001F, "sweep_x31_unswept");
         exp_d(1, (k <= 2) ? 32'h10000002 : 32'h0, "sweep_x2");
         exp_b(2, k <= 9, "sweep_x9_busy");
         exp_b(3, 1'b0, "sweep_x3_no_issue");
      end
      cyc();
      quiet();
      writeEnable = 1'b1; writeAddr = 5'd6; writeData = 32'h00000066;
      set_ra(0, 0, 0, 0);
      exp_c(1'b0, "sweep_done_cb");
      for (int a = 1; a < NREGS; a++) begin
         cyc();
         quiet();
         set_ra(0, a, 0, 0);
         exp_d(1, (a == 6) ? 32'h00000066 : 32'h0, "post_sweep_data");
         exp_b(1, 1'b0, "post_sweep_busy");
      end

      // Reset mid-sweep.
      cyc();
      writeEnable = 1'b1; writeAddr = 5'd20; writeData = 32'hABCD0020;
      cyc();
      quiet();
      clearReq = 1'b1;
      set_ra(20, 6, 0, 0);
      exp_d(0, 32'hABCD0020, "pre_abort_x20");
      for (int k = 1; k <= 10; k++) begin
         cyc();
         quiet();
         exp_c(1'b1, "abort_sweep_cb");
      end
      cyc();
      rst = 1'b0;
      exp_c(1'b0, "abort_cb_immediate");
      exp_d(0, 32'h0, "abort_x20_in_reset");
      cyc();
      rst = 1'b1;
      exp_c(1'b0, "abort_cb_release");
      cyc();
      exp_d(0, 32'h0, "abort_x20_after");
      exp_d(1, 32'h0, "abort_x6_after");
      exp_c(1'b0, "abort_cb_after");

      cyc();
      cyc();
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL pending_checks: got %0d left, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
